// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_ADDC = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_LSH  = 4'd8;
  localparam logic [3:0] OP_RSH  = 4'd9;
  localparam logic [3:0] OP_ARSH = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  // Bit positions inside the 5-bit {Z,C,F,N,L} flag vector.
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_L = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per clock.
// The start edge seeds the cleared accumulator with bit 0's partial product and
// loads the counter with WIDTH-1 (bits still to process); each following edge
// folds in one more bit. done is high on the edge that takes the counter to 0,
// and product then carries the final value for the caller to register.
module alu_mul_iter #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  // Next-state for the multiplier datapath: load on start, step while counting.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = b[0] ? a : '0;
      mcand_d  = a << 1;
      mplier_d = b >> 1;
      cnt_d    = SHW'(WIDTH - 1);
    end else if (cnt_q != '0) begin
      acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - SHW'(1);
    end
  end

  assign done    = (cnt_q == SHW'(1)) && !start;
  assign product = acc_d;

  // Multiplier state registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with persistent ZCFNL flags and an iterative multiplier.
// Handshake: a request is taken on any rising edge where in_valid && in_ready;
// in_ready is high exactly while the FSM is IDLE (including the out_valid cycle),
// and out_valid is a one-cycle pulse marking a fresh result/flags pair.
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic [4:0]       flags,
  output alu_state_e       dbg_state
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0] alu_res;
  logic [4:0]       alu_flags;
  logic             alu_nop;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   sh;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle datapath: result and flag candidates for every non-MUL opcode.
  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    alu_nop   = 1'b0;
    sh        = b[SHW-1:0];
    sum       = {1'b0, a} + {1'b0, b}
              + {{WIDTH{1'b0}}, (op == OP_ADDC) ? flags_q[FLAG_C] : 1'b0};
    diff      = {1'b0, a} - {1'b0, b};
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOT:  alu_res = ~a;
      OP_ADD, OP_ADDC: begin
        alu_res           = sum[WIDTH-1:0];
        alu_flags[FLAG_C] = sum[WIDTH];
        alu_flags[FLAG_F] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res           = diff[WIDTH-1:0];
        alu_flags[FLAG_C] = diff[WIDTH];
        alu_flags[FLAG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_CMP: begin
        alu_res           = '0;
        alu_flags[FLAG_N] = $signed(a) < $signed(b);
        alu_flags[FLAG_L] = a < b;
      end
      OP_LSH:  alu_res = a << sh;
      OP_RSH:  alu_res = a >> sh;
      OP_ARSH: alu_res = $unsigned($signed(a) >>> sh);
      OP_MUL:  alu_res = '0;
      default: alu_nop = 1'b1;
    endcase
    // CMP defines Z from operand equality; every other op from its result.
    alu_flags[FLAG_Z] = (op == OP_CMP) ? (a == b) : (alu_res == '0);
  end

  // Control FSM: accept in IDLE, wait on the multiplier in BUSY, write outputs on completion.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    mul_start   = 1'b0;
    in_ready    = (state_q == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_BUSY;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            if (!alu_nop) flags_d = alu_flags;
          end
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d          = ST_IDLE;
          out_valid_d      = 1'b1;
          result_d         = mul_product;
          flags_d          = '0;
          flags_d[FLAG_Z]  = (mul_product == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, result, flag and out_valid registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign flags     = flags_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

endmodule
